// File: rtl/sbox_pkg.sv
// -----------------------------------------------------------------------------
// sbox_pkg
// Shared constants, FSM state type and lane helper for the byte-substitution
// engine (sbox_stream_engine and its pipeline slices).
// -----------------------------------------------------------------------------
package sbox_pkg;

    localparam int BYTE_W      = 8;
    localparam int TABLE_DEPTH = 256;
    localparam int MAX_LANES   = 16;
    // Widest datapath the lane helper accepts; narrower beats are zero-padded.
    localparam int LANE_VEC_W  = MAX_LANES * BYTE_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Extract byte lane 'lane' (bits [8*lane+7:8*lane]) from a padded beat.
    function automatic logic [BYTE_W-1:0] lane_byte(input logic [LANE_VEC_W-1:0] v,
                                                     input int                    lane);
        return v[lane*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/sbox_pipe_slice.sv
// -----------------------------------------------------------------------------
// sbox_pipe_slice
// One valid/ready register stage. Accepts a new word whenever it is empty or
// its current word is being taken downstream in the same cycle. Held data does
// not change while out_valid_o && !out_ready_i.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i     upstream handshake + payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake + payload
// -----------------------------------------------------------------------------
module sbox_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            // Data only moves with a real beat so the output stays quiet when idle.
            if (in_valid_i) data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/sbox_stream_engine.sv
// -----------------------------------------------------------------------------
// sbox_stream_engine
// Multi-lane byte substitution: every byte of each input beat is replaced via a
// run-time loaded 256x8 table. Two-stage valid/ready pipeline (register input,
// then register per-lane lookup) with full backpressure.
//
// Optional build macro: SBOX_INVERSE_EN
//   defined   - an inverse table is built during load (inv[data] = addr) and the
//               per-beat 'mode' bit selects forward (0) or inverse (1) lookup.
//   undefined - 'mode' is ignored, forward table only.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cfg_start, cfg_valid, cfg_data  table (re)load stream, addresses 0..255
//   cfg_done                      table loaded and engine in RUN
//   mode                          per-beat table select (inverse build only)
//   in_valid/in_ready/in_data     input beat stream, lane i = bits [8i+7:8i]
//   out_valid/out_ready/out_data  substituted beat stream, lane order kept
// -----------------------------------------------------------------------------
module sbox_stream_engine
    import sbox_pkg::*;
#(
    parameter  int LANES  = 4,
    localparam int DATA_W = LANES * BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic [BYTE_W-1:0] cfg_data,
    output logic              cfg_done,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [BYTE_W-1:0] LAST_ADDR = BYTE_W'(TABLE_DEPTH - 1);

`ifdef SBOX_INVERSE_EN
    localparam int S1_W = DATA_W + 1;   // mode bit travels with the beat
`else
    localparam int S1_W = DATA_W;
`endif

    state_e            state_q;
    logic [BYTE_W-1:0] addr_q;
    logic              cfg_done_q;

    logic [BYTE_W-1:0] fwd_mem [TABLE_DEPTH];
`ifdef SBOX_INVERSE_EN
    logic [BYTE_W-1:0] inv_mem [TABLE_DEPTH];
`endif

    logic              s1_in_valid, s1_ready, s1_valid;
    logic [S1_W-1:0]   s1_in_data, s1_data;
    logic              s2_ready;
    logic [DATA_W-1:0] lut_data;
    logic              pipe_empty, load_wr;

    assign cfg_done   = cfg_done_q;
    assign pipe_empty = !s1_valid && !out_valid;
    assign load_wr    = (state_q == ST_LOAD) && cfg_valid;

    // A cfg_start in RUN closes the input in the same cycle, whether the
    // engine goes straight to LOAD or drains first.
    assign in_ready    = (state_q == ST_RUN) && !cfg_start && s1_ready;
    assign s1_in_valid = in_valid && in_ready;

`ifdef SBOX_INVERSE_EN
    assign s1_in_data = {mode, in_data};
`else
    assign s1_in_data = in_data;
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            addr_q     <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (cfg_start) begin
                        state_q <= ST_LOAD;
                        addr_q  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (cfg_valid) begin
                        addr_q <= addr_q + 1'b1;   // wraps to 0 after the last entry
                        if (addr_q == LAST_ADDR) begin
                            state_q    <= ST_RUN;
                            cfg_done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cfg_start) begin
                        cfg_done_q <= 1'b0;
                        addr_q     <= '0;
                        state_q    <= pipe_empty ? ST_LOAD : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        state_q <= ST_LOAD;
                        addr_q  <= '0;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    // Table storage is deliberately not reset; a full reload is required.
    always_ff @(posedge clk) begin
        if (load_wr) begin
            fwd_mem[addr_q] <= cfg_data;
`ifdef SBOX_INVERSE_EN
            inv_mem[cfg_data] <= addr_q;
`endif
        end
    end

    // ---------------- pipeline ----------------
    sbox_pipe_slice #(.W(S1_W)) u_stage1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (s1_in_valid),
        .in_ready_o (s1_ready),
        .in_data_i  (s1_in_data),
        .out_valid_o(s1_valid),
        .out_ready_i(s2_ready),
        .out_data_o (s1_data)
    );

    // All lanes look up the shared table in parallel on the stage-1 beat.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [BYTE_W-1:0] idx;
        assign idx = lane_byte(LANE_VEC_W'(s1_data[DATA_W-1:0]), l);
`ifdef SBOX_INVERSE_EN
        assign lut_data[l*BYTE_W +: BYTE_W] = s1_data[DATA_W] ? inv_mem[idx] : fwd_mem[idx];
`else
        assign lut_data[l*BYTE_W +: BYTE_W] = fwd_mem[idx];
`endif
    end

    sbox_pipe_slice #(.W(DATA_W)) u_stage2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (s1_valid),
        .in_ready_o (s2_ready),
        .in_data_i  (lut_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data)
    );

endmodule
